// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 16:1 mux.
// One tenure per grant; it ends on ack, on withdrawal, or when the hold limit expires.
module mux16_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        ack,
    output logic [3:0]  s,
    output logic [15:0] grant,
    output logic        valid,
    output logic        timeout
);

    localparam int CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state, state_nx;
    logic [3:0]     last, last_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [3:0]     s_nx;
    logic [15:0]    grant_nx;
    logic           valid_nx;
    logic           timeout_nx;
    logic [4:0]     win;
    logic           held_req;
    logic           expire;

    // Returns {found, index}; scans ptr+1 upward, wrapping, so ptr itself is seen last.
    function automatic logic [4:0] pick(input logic [15:0] r, input logic [3:0] ptr);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int k = 16; k >= 1; k--) begin
            idx = ptr + 4'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        state_nx   = state;
        last_nx    = last;
        cnt_nx     = cnt;
        s_nx       = s;
        grant_nx   = grant;
        valid_nx   = valid;
        timeout_nx = 1'b0;
        held_req   = req[s];
        expire     = (cnt == CNT_LAST);
        win        = pick(req, (state == BUSY) ? s : last);

        case (state)
            IDLE: begin
                if (win[4]) begin
                    state_nx = BUSY;
                    s_nx     = win[3:0];
                    grant_nx = 16'd1 << win[3:0];
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                end
            end
            BUSY: begin
                if (ack || !held_req || expire) begin
                    // Only the hold limit is left as a cause once ack and withdrawal are excluded.
                    timeout_nx = !ack && held_req;
                    last_nx    = s;
                    if (win[4]) begin
                        s_nx     = win[3:0];
                        grant_nx = 16'd1 << win[3:0];
                        cnt_nx   = '0;
                    end else begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        valid_nx = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 4'd15;
            cnt     <= '0;
            s       <= '0;
            grant   <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            last    <= last_nx;
            cnt     <= cnt_nx;
            s       <= s_nx;
            grant   <= grant_nx;
            valid   <= valid_nx;
            timeout <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: a vector table for the single-cycle
// behaviour plus hand-written sequences for hold expiry and async reset.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        ack;
    logic [3:0]  s;
    logic [15:0] grant;
    logic        valid;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] req;
        logic        ack;
        logic        e_valid;
        logic [3:0]  e_s;
        logic [15:0] e_grant;
        logic        e_timeout;
    } vec_t;

    vec_t vecs[$];

    mux16_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .ack(ack),
        .s(s),
        .grant(grant),
        .valid(valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [15:0] r, input logic a, input logic v,
                       input logic [3:0] es, input logic [15:0] eg, input logic et);
        vec_t x;
        x.req = r; x.ack = a; x.e_valid = v; x.e_s = es; x.e_grant = eg; x.e_timeout = et;
        vecs.push_back(x);
    endtask

    // Inputs are applied at a falling edge and outputs sampled at the next falling edge.
    task automatic cyc(input logic [15:0] r, input logic a);
        req = r;
        ack = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic v, input logic [3:0] es,
                         input logic [15:0] eg, input logic et);
        checks++;
        if (valid !== v || s !== es || grant !== eg || timeout !== et) begin
            errors++;
            $display("FAIL %s: got valid=%b s=%0d grant=%h timeout=%b, expected valid=%b s=%0d grant=%h timeout=%b",
                     name, valid, s, grant, timeout, v, es, eg, et);
        end
    endtask

    initial begin
        int sx;
        // Basic grant / release and ack ignored while idle
        add(16'h0001, 1'b0, 1'b1, 4'd0,  16'h0001, 1'b0);
        add(16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0);
        add(16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0);
        // All requesting: last=0, so the first grant goes to 1, then ack rotates every cycle
        add(16'hFFFF, 1'b0, 1'b1, 4'd1,  16'h0002, 1'b0);
        for (int i = 0; i < 16; i++) begin
            sx = (i + 2) % 16;
            add(16'hFFFF, 1'b1, 1'b1, 4'(sx), 16'd1 << sx, 1'b0);
        end
        // Wrap-around between 15 and 0
        add(16'h8001, 1'b1, 1'b1, 4'd15, 16'h8000, 1'b0);
        add(16'h8001, 1'b1, 1'b1, 4'd0,  16'h0001, 1'b0);
        add(16'h8001, 1'b1, 1'b1, 4'd15, 16'h8000, 1'b0);
        // Withdrawal hand-off without bubble, then withdrawal to idle keeps s
        add(16'h0030, 1'b0, 1'b1, 4'd4,  16'h0010, 1'b0);
        add(16'h0030, 1'b0, 1'b1, 4'd4,  16'h0010, 1'b0);
        add(16'h0020, 1'b0, 1'b1, 4'd5,  16'h0020, 1'b0);
        add(16'h0000, 1'b0, 1'b0, 4'd5,  16'h0000, 1'b0);

        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
        #1;
        check("reset_state", 1'b0, 4'd0, 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(16'h0000, 1'b0);
        check("idle_after_reset", 1'b0, 4'd0, 16'h0000, 1'b0);

        foreach (vecs[i]) begin
            cyc(vecs[i].req, vecs[i].ack);
            check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_s,
                  vecs[i].e_grant, vecs[i].e_timeout);
        end

        // Hold expiry: sole requester 5, timeout 8 cycles after grant, then
        // on the second tenure an ack on the expiry cycle suppresses timeout.
        cyc(16'h0020, 1'b0);
        check("to_grant", 1'b1, 4'd5, 16'h0020, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            cyc(16'h0020, (k == 16) ? 1'b1 : 1'b0);
            check($sformatf("to_cyc%0d", k), 1'b1, 4'd5, 16'h0020, (k == 8) ? 1'b1 : 1'b0);
        end
        cyc(16'h0000, 1'b0);
        check("to_release", 1'b0, 4'd5, 16'h0000, 1'b0);

        // Async reset mid-tenure, search restarts from index 0
        cyc(16'h0200, 1'b0);
        check("pre_reset_grant", 1'b1, 4'd9, 16'h0200, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_drop", 1'b0, 4'd0, 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(16'h0200, 1'b0);
        check("post_reset_grant", 1'b1, 4'd9, 16'h0200, 1'b0);
        cyc(16'h1020, 1'b0);
        check("withdraw_to_12", 1'b1, 4'd12, 16'h1000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_drop2", 1'b0, 4'd0, 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(16'h1020, 1'b0);
        check("reset_pointer_15", 1'b1, 4'd5, 16'h0020, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
